// File: rtl/i2c_adc_responder_if.sv
// Open-drain I2C pad bundle shared by the ADC-emulating responder and
// whatever drives the bus (a real pad ring or a bench master).
// sda_oe only ever pulls SDA low; the bus owner forms the wired-AND.
interface i2c_adc_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_adc_responder.sv
// I2C target that emulates the board ADC: it accepts an address+W and
// command bytes, then answers address+R with a snapshot of sample_data,
// MSB first, one byte per master ACK. SDA is only ever pulled low.
module i2c_adc_responder #(
  parameter logic [6:0] ADDR      = 7'h20,
  parameter int         NUM_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  i2c_adc_responder_if.slave     bus,
  input  logic [8*NUM_BYTES-1:0] sample_data,
  output logic [7:0]             cmd_out,
  output logic                   cmd_valid,
  output logic                   rd_done,
  output logic                   busy
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RX,
    ADDR_ACK,
    CMD_RX,
    CMD_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } state_t;

  // Synchronized pad samples plus one-cycle history for edge detection.
  logic scl_s1, scl_s2, scl_q;
  logic sda_s1, sda_s2, sda_q;

  logic scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   phase_q, phase_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [7:0]             cmd_out_q, cmd_out_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   rd_done_q, rd_done_d;

  logic [7:0] rx_byte;
  logic [7:0] cur_byte;

  // Two-flop synchronizers on the asynchronous pads, idling high like the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_q  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= bus.sda_i;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;

  // The bit arriving on this SCL rise completes the byte shifted in so far.
  assign rx_byte = {shift_q[6:0], sda_s2};

  // Select the shadow byte being transmitted; byte 0 sits in the top bits.
  always_comb begin
    cur_byte = shadow_q[8*NUM_BYTES-1 -: 8];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_idx_q == IDX_W'(i)) begin
        cur_byte = shadow_q[8*(NUM_BYTES-1-i) +: 8];
      end
    end
  end

  // State and datapath registers; async reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      phase_q     <= 1'b0;
      byte_idx_q  <= '0;
      shadow_q    <= '0;
      sda_oe_q    <= 1'b0;
      cmd_out_q   <= 8'h00;
      cmd_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      byte_idx_q  <= byte_idx_d;
      shadow_q    <= shadow_d;
      sda_oe_q    <= sda_oe_d;
      cmd_out_q   <= cmd_out_d;
      cmd_valid_q <= cmd_valid_d;
      rd_done_q   <= rd_done_d;
    end
  end

  // Protocol FSM: START/STOP override everything, otherwise bits are taken
  // on SCL rise and SDA is only re-driven on SCL fall. phase marks the
  // second half of an ACK slot (ACK already driven / master ACK seen).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    byte_idx_d  = byte_idx_q;
    shadow_d    = shadow_q;
    sda_oe_d    = sda_oe_q;
    cmd_out_d   = cmd_out_q;
    cmd_valid_d = 1'b0;
    rd_done_d   = 1'b0;

    if (start_det) begin
      state_d   = ADDR_RX;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR_RX: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              if (rx_byte[7:1] == ADDR) begin
                state_d = ADDR_ACK;
                phase_d = 1'b0;
                if (rx_byte[0]) begin
                  shadow_d   = sample_data;
                  byte_idx_d = '0;
                end
              end else begin
                state_d  = WAIT_STOP;
                sda_oe_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (shift_q[0]) begin
                sda_oe_d = ~cur_byte[7];
                state_d  = TX_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = CMD_RX;
              end
            end
          end
        end

        CMD_RX: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = 3'd0;
              cmd_out_d   = rx_byte;
              cmd_valid_d = 1'b1;
              phase_d     = 1'b0;
              state_d     = CMD_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        CMD_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = CMD_RX;
            end
          end
        end

        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = TX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              sda_oe_d  = ~cur_byte[3'd6 - bit_cnt_q];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_s2) begin
              phase_d    = 1'b1;
              byte_idx_d = (byte_idx_q == IDX_W'(NUM_BYTES-1)) ? '0
                                                              : byte_idx_q + IDX_W'(1);
            end else begin
              rd_done_d = 1'b1;
              sda_oe_d  = 1'b0;
              state_d   = WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            sda_oe_d  = ~cur_byte[7];
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = TX_BYTE;
          end
        end

        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign cmd_out    = cmd_out_q;
  assign cmd_valid  = cmd_valid_q;
  assign rd_done    = rd_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Bench for i2c_adc_responder: a bit-banged I2C master drives the bus,
// a transaction-level model predicts ACKs, command bytes, read payload and
// pulse counts, and one per-cycle monitor checks the DUT against it.
module tb_i2c_adc_responder;

  localparam logic [6:0] ADDR      = 7'h20;
  localparam int         NUM_BYTES = 8;
  localparam int         Q         = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   m_scl;
  logic                   m_sda;
  logic [8*NUM_BYTES-1:0] sample_data;
  logic [7:0]             cmd_out;
  logic                   cmd_valid;
  logic                   rd_done;
  logic                   busy;

  int total = 0;
  int bad   = 0;
  int cv_cycles = 0;
  int rd_cycles = 0;
  int exp_cv = 0;
  int exp_rd = 0;

  logic [7:0] exp_cmd_q [$];
  logic [7:0] model_cmd = 8'h00;
  logic       expect_released = 1'b0;
  logic [7:0] snap [NUM_BYTES];
  logic [7:0] rd_bytes [16];

  i2c_adc_responder_if bus ();

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_adc_responder #(
    .ADDR      (ADDR),
    .NUM_BYTES (NUM_BYTES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sample_data (sample_data),
    .cmd_out     (cmd_out),
    .cmd_valid   (cmd_valid),
    .rd_done     (rd_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every command pulse must match the next predicted command,
  // cmd_out must hold the last predicted command, pulses never overlap,
  // and SDA stays released whenever the model says the DUT is silent.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_cmd = 8'h00;
    end else begin
      if (cmd_valid) begin
        cv_cycles++;
        checkOutput("cmd_valid_expected", exp_cmd_q.size() > 0, 1);
        if (exp_cmd_q.size() > 0) model_cmd = exp_cmd_q.pop_front();
      end
      if (rd_done) rd_cycles++;
      checkOutput("cmd_out_track", cmd_out, model_cmd);
      checkOutput("pulse_exclusive", cmd_valid & rd_done, 0);
      if (expect_released) checkOutput("sda_released", bus.sda_oe, 0);
    end
  end

  // Hang guard: reports and stops if the stimulus never completes.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL clock: master puts bit_in on SDA, returns the wired-AND line
  // value sampled in the middle of SCL high.
  task automatic applyStimulus(input logic bit_in, output logic seen);
    m_sda = bit_in;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    seen = bus.sda_i;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    checkOutput("busy_after_start", busy, 1);
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    wait_q();
    checkOutput("busy_after_stop", busy, 0);
    expect_released = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], seen);
    applyStimulus(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, seen);
      b[i] = seen;
    end
    applyStimulus(ack_bit, seen);
  endtask

  // Address phase; a read to our address freezes the model payload here.
  task automatic send_addr(input logic [6:0] addr, input logic rw, output logic matched);
    logic ack;
    matched = (addr == ADDR);
    if (!matched) expect_released = 1'b1;
    if (matched && rw) begin
      for (int k = 0; k < NUM_BYTES; k++) snap[k] = sample_data[8*(NUM_BYTES-1-k) +: 8];
    end
    write_byte({addr, rw}, ack);
    checkOutput("addr_ack", ack, matched ? 1'b0 : 1'b1);
  endtask

  task automatic send_cmds(input logic matched, input logic [7:0] first, input int n);
    logic       ack;
    logic [7:0] c;
    for (int k = 0; k < n; k++) begin
      c = (k == 0) ? first : 8'($urandom);
      if (matched) begin
        exp_cmd_q.push_back(c);
        exp_cv++;
      end
      write_byte(c, ack);
      checkOutput("cmd_ack", ack, matched ? 1'b0 : 1'b1);
    end
  endtask

  // Read n bytes, ACK all but the last; the payload repeats every NUM_BYTES.
  task automatic do_read(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      read_byte(k == n-1, b);
      checkOutput("read_byte", b, snap[k % NUM_BYTES]);
      if (k < 16) rd_bytes[k] = b;
    end
    exp_rd++;
    expect_released = 1'b1;
  endtask

  task automatic check_counts();
    checkOutput("cmd_valid_count", cv_cycles, exp_cv);
    checkOutput("rd_done_count", rd_cycles, exp_rd);
    checkOutput("cmd_queue_drained", exp_cmd_q.size(), 0);
  endtask

  function automatic logic [6:0] other_addr();
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    if (a == ADDR) a = a ^ 7'h01;
    return a;
  endfunction

  initial begin
    logic       m;
    logic       m2;
    logic       seen;
    logic [6:0] a;
    int         kind;

    rst_n       = 1'b0;
    m_scl       = 1'b1;
    m_sda       = 1'b1;
    sample_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sda_oe", bus.sda_oe, 0);
    checkOutput("reset_cmd_out", cmd_out, 8'h00);
    checkOutput("reset_cmd_valid", cmd_valid, 0);
    checkOutput("reset_rd_done", rd_done, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] scenario 1: write command");
    i2c_start();
    send_addr(ADDR, 1'b0, m);
    send_cmds(m, 8'hF0, 1);
    i2c_stop();
    check_counts();
    checkOutput("s1_cmd_out", cmd_out, 8'hF0);

    $display("[TB] scenario 2: foreign address");
    i2c_start();
    send_addr(7'h21, 1'b0, m);
    send_cmds(m, 8'h5A, 1);
    i2c_stop();
    check_counts();
    checkOutput("s2_cmd_out", cmd_out, 8'hF0);

    $display("[TB] scenario 3: full ADC frame");
    sample_data = 64'h0011_2233_4455_6677;
    i2c_start();
    send_addr(ADDR, 1'b0, m);
    send_cmds(m, 8'hF0, 1);
    i2c_start();
    send_addr(ADDR, 1'b1, m);
    do_read(8);
    i2c_stop();
    check_counts();
    checkOutput("s3_byte0", rd_bytes[0], 8'h00);
    checkOutput("s3_byte3", rd_bytes[3], 8'h33);
    checkOutput("s3_byte7", rd_bytes[7], 8'h77);

    $display("[TB] scenario 4: payload change after address ACK");
    sample_data = 64'hA1B2_C3D4_E5F6_0718;
    i2c_start();
    send_addr(ADDR, 1'b1, m);
    sample_data = '1;
    do_read(8);
    i2c_stop();
    check_counts();
    checkOutput("s4_byte0", rd_bytes[0], 8'hA1);
    checkOutput("s4_byte7", rd_bytes[7], 8'h18);

    $display("[TB] scenario 5: index wrap");
    sample_data = 64'h0011_2233_4455_6677;
    i2c_start();
    send_addr(ADDR, 1'b1, m);
    do_read(10);
    i2c_stop();
    check_counts();
    checkOutput("s5_byte9", rd_bytes[8], 8'h00);
    checkOutput("s5_byte10", rd_bytes[9], 8'h11);

    $display("[TB] scenario 6: reset during ACK");
    i2c_start();
    for (int i = 7; i >= 0; i--) applyStimulus(((i == 0) ? 1'b0 : ADDR[i-1]), seen);
    m_sda = 1'b1;
    wait_q();
    checkOutput("s6_ack_driven", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_async_release", bus.sda_oe, 0);
    checkOutput("s6_cmd_out_reset", cmd_out, 8'h00);
    m_scl = 1'b1;
    wait_q();
    wait_q();
    m_scl = 1'b0;
    wait_q();
    rst_n = 1'b1;
    expect_released = 1'b1;
    send_cmds(1'b0, 8'hC3, 1);
    i2c_stop();
    check_counts();
    i2c_start();
    send_addr(ADDR, 1'b0, m);
    send_cmds(m, 8'h3C, 1);
    i2c_stop();
    check_counts();
    checkOutput("s6_rearm_cmd", cmd_out, 8'h3C);

    $display("[TB] randomized transactions");
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 1) ? ADDR : other_addr();
      sample_data = {$urandom, $urandom};
      i2c_start();
      if (kind == 0) begin
        send_addr(a, 1'b0, m);
        send_cmds(m, 8'($urandom), $urandom_range(1, 3));
      end else if (kind == 1) begin
        send_addr(ADDR, 1'b0, m);
        send_cmds(m, 8'($urandom), 1);
        i2c_start();
        send_addr(a, 1'b1, m2);
        if (m2) begin
          if ($urandom_range(0, 1) == 1) sample_data = {$urandom, $urandom};
          do_read($urandom_range(1, 10));
        end
      end else begin
        send_addr(a, 1'b1, m);
        if (m) do_read($urandom_range(1, 10));
      end
      i2c_stop();
      check_counts();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
